// File: rtl/mux_sel_sequencer.sv
// Scans an 8-to-1 mux select through all eight settings, samples the mux
// output at the end of each hold window, and emits the samples both as a
// serial stream and as a packed word {A,B,C,D,E,F,G,H}.
module mux_sel_sequencer #(
  parameter int unsigned HOLD = 1  // cycles per sel value, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       q_in,
  output logic [2:0] sel,
  output logic       busy,
  output logic       bit_valid,
  output logic       bit_out,
  output logic       done,
  output logic [7:0] word
);

  localparam logic [3:0] HoldLast = 4'(HOLD - 1);

  typedef enum logic {StIdle, StScan} state_e;

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [2:0]  sel_q, sel_d;
  logic [3:0]  hold_q, hold_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        bit_valid_q, bit_valid_d;
  logic        bit_out_q, bit_out_d;
  logic        done_q, done_d;
  logic [7:0]  word_q, word_d;

  // Next-state: accept start in idle, step the hold/sample counters while scanning.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sel_d       = sel_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    bit_valid_d = 1'b0;
    bit_out_d   = bit_out_q;
    done_d      = 1'b0;
    word_d      = word_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          busy_d  = 1'b1;
          mode_d  = mode;
          sel_d   = mode ? 3'd7 : 3'd0;
          word_d  = 8'h00;
          hold_d  = 4'd0;
          cnt_d   = 3'd0;
        end
      end
      StScan: begin
        if (hold_q == HoldLast) begin
          hold_d             = 4'd0;
          bit_valid_d        = 1'b1;
          bit_out_d          = q_in;
          word_d[3'd7-sel_q] = q_in;
          cnt_d              = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            // Last sample: sel parks on the final index, no wrap.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            sel_d = mode_q ? sel_q - 3'd1 : sel_q + 3'd1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset that discards any partial scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      sel_q       <= 3'd0;
      hold_q      <= 4'd0;
      cnt_q       <= 3'd0;
      busy_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      done_q      <= 1'b0;
      word_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      done_q      <= done_d;
      word_q      <= word_d;
    end
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;
  assign done      = done_q;
  assign word      = word_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench: two instances (HOLD=1 and HOLD=3) each driving a model of
// the downstream mux, checked with immediate assertions after each edge.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst, mode;
  logic       start1, start3;
  logic [7:0] mux_in;

  logic       q1, q3;
  logic [2:0] sel1, sel3;
  logic       busy1, busy3, bv1, bv3, bo1, bo3, done1, done3;
  logic [7:0] word1, word3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Combinational mux model: sel=0 picks A (mux_in[7]), sel=7 picks H (mux_in[0]).
  assign q1 = mux_in[3'd7 - sel1];
  assign q3 = mux_in[3'd7 - sel3];

  mux_sel_sequencer #(.HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .q_in(q1),
    .sel(sel1), .busy(busy1), .bit_valid(bv1), .bit_out(bo1), .done(done1), .word(word1)
  );

  mux_sel_sequencer #(.HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode), .q_in(q3),
    .sel(sel3), .busy(busy3), .bit_valid(bv3), .bit_out(bo3), .done(done3), .word(word3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run up to a bounded number of cycles waiting for done on the HOLD=1 instance.
  task automatic wait_done1(output logic seen);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (done1) seen = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] stream;
    logic       seen;
    logic       m;

    // 1. Reset with start and q_in forced high.
    rst = 1'b1; start1 = 1'b1; start3 = 1'b1; mode = 1'b0; mux_in = 8'hFF;
    tick();
    tick();
    check("rst_sel", 8'(sel1), 8'd0);
    check("rst_busy", 8'(busy1), 8'd0);
    check("rst_bv", 8'(bv1), 8'd0);
    check("rst_bo", 8'(bo1), 8'd0);
    check("rst_done", 8'(done1), 8'd0);
    check("rst_word", word1, 8'h00);
    check("rst_busy3", 8'(busy3), 8'd0);
    rst = 1'b0; start1 = 1'b0; start3 = 1'b0;
    tick();

    // 2. Ascending, HOLD=1, inputs B2.
    mux_in = 8'hB2; mode = 1'b0; stream = 8'b1011_0010;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("asc_start_busy", 8'(busy1), 8'd1);
    check("asc_start_sel", 8'(sel1), 8'd0);
    check("asc_start_word", word1, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("asc_bv", 8'(bv1), 8'd1);
      check("asc_bit", 8'(bo1), 8'(stream[8-k]));
      check("asc_done", 8'(done1), (k == 8) ? 8'd1 : 8'd0);
      check("asc_sel", 8'(sel1), (k < 8) ? 8'(k) : 8'd7);
      check("asc_busy", 8'(busy1), (k < 8) ? 8'd1 : 8'd0);
    end
    check("asc_word", word1, 8'hB2);
    tick();
    check("asc_done_pulse", 8'(done1), 8'd0);

    // 3. Descending, HOLD=3, inputs 17.
    mux_in = 8'h17; mode = 1'b1; stream = 8'b1110_1000;
    start3 = 1'b1;
    tick();
    start3 = 1'b0; mode = 1'b0;
    check("dsc_start_sel", 8'(sel3), 8'd7);
    check("dsc_start_busy", 8'(busy3), 8'd1);
    for (int k = 1; k <= 8; k++) begin
      for (int h = 1; h <= 3; h++) begin
        tick();
        if (h < 3) begin
          check("dsc_hold_bv", 8'(bv3), 8'd0);
          check("dsc_hold_sel", 8'(sel3), 8'(8 - k));
          check("dsc_hold_busy", 8'(busy3), 8'd1);
        end else begin
          check("dsc_bv", 8'(bv3), 8'd1);
          check("dsc_bit", 8'(bo3), 8'(stream[8-k]));
          check("dsc_done", 8'(done3), (k == 8) ? 8'd1 : 8'd0);
          check("dsc_sel", 8'(sel3), (k < 8) ? 8'(7 - k) : 8'd0);
          check("dsc_busy", 8'(busy3), (k < 8) ? 8'd1 : 8'd0);
        end
      end
    end
    check("dsc_word", word3, 8'h17);

    // 4. Start during busy is ignored; back-to-back start in the done cycle.
    mux_in = 8'hC3; mode = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick(); tick(); tick();            // S+4
    start1 = 1'b1; mode = 1'b1;
    tick();                                    // S+5
    start1 = 1'b0; mode = 1'b0;
    check("b2b_norestart_sel", 8'(sel1), 8'd5);
    tick(); tick();                            // S+7
    check("b2b_not_yet", 8'(done1), 8'd0);
    tick();                                    // S+8
    check("b2b_done1", 8'(done1), 8'd1);
    check("b2b_word1", word1, 8'hC3);
    mux_in = 8'h5A; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("b2b_restart_busy", 8'(busy1), 8'd1);
    check("b2b_restart_sel", 8'(sel1), 8'd0);
    check("b2b_restart_word", word1, 8'h00);
    tick();
    check("b2b_first_bv", 8'(bv1), 8'd1);
    check("b2b_first_bit", 8'(bo1), 8'd0);
    wait_done1(seen);
    check("b2b_done2_seen", 8'(seen), 8'd1);
    check("b2b_word2", word1, 8'h5A);

    // 5. Reset mid-scan, then a clean scan.
    mux_in = 8'hFF; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick(); tick(); tick();
    check("mid_sel_before", 8'(sel1), 8'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_word", word1, 8'h00);
    check("mid_busy", 8'(busy1), 8'd0);
    check("mid_done", 8'(done1), 8'd0);
    check("mid_sel", 8'(sel1), 8'd0);
    check("mid_bv", 8'(bv1), 8'd0);
    tick();
    check("mid_stays_idle", 8'(busy1), 8'd0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done1(seen);
    check("mid_after_seen", 8'(seen), 8'd1);
    check("mid_after_word", word1, 8'hFF);

    // 6. Sweep with alternating mode.
    m = 1'b0;
    for (int i = 0; i <= 253; i += 23) begin
      mux_in = 8'(i); mode = m; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      wait_done1(seen);
      check("sweep_seen", 8'(seen), 8'd1);
      check("sweep_word", word1, 8'(i));
      m = ~m;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
